reg_read_unit: RTL and testbench



---
 rtl/reg_read_unit_if.sv | 55 +++++
 rtl/reg_read_unit.sv | 158 +++++++++++++++
 tb/tb_reg_read_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_read_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_read_unit_if
// Description : Bus bundle between the sequencer, the register bank and the
//               operand read port: read command, bank contents, write snoop
//               source, and the captured-operand valid/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_read_unit_if #(
    parameter int REG_W = 32,
    parameter int SEL_W = 3
);
    // Command and select lines from the sequencer
    logic [3:0]       read_or_write;
    logic [SEL_W-1:0] src_sel;
    logic [SEL_W-1:0] dst_sel;

    // Current register bank contents, x86 order
    logic [REG_W-1:0] eax;
    logic [REG_W-1:0] ecx;
    logic [REG_W-1:0] edx;
    logic [REG_W-1:0] ebx;
    logic [REG_W-1:0] esp;
    logic [REG_W-1:0] ebp;
    logic [REG_W-1:0] esi;
    logic [REG_W-1:0] edi;

    // Write landing in the bank on this edge (snoop source)
    logic [REG_W-1:0] write_data;
    logic [SEL_W-1:0] write_sel;

    // Operand handshake
    logic             read_ack;
    logic [REG_W-1:0] operand_a;
    logic [REG_W-1:0] operand_b;
    logic             read_valid;
    logic             busy;

    // Sequencer / bank side
    modport master (
        output read_or_write, src_sel, dst_sel,
        output eax, ecx, edx, ebx, esp, ebp, esi, edi,
        output write_data, write_sel, read_ack,
        input  operand_a, operand_b, read_valid, busy
    );

    // Read unit side
    modport slave (
        input  read_or_write, src_sel, dst_sel,
        input  eax, ecx, edx, ebx, esp, ebp, esi, edi,
        input  write_data, write_sel, read_ack,
        output operand_a, operand_b, read_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/reg_read_unit.sv
`default_nettype none
// ============================================================================
// Module      : reg_read_unit
// Description : Operand read port for the CPU register bank. Captures one or
//               two operands selected by x86 register encoding, holds them
//               under a valid/ack handshake and reports busy while a read is
//               outstanding.
//               Optional feature macro: REG_READ_SNOOP_EN - when defined, held
//               operands follow bank writes that target their source register
//               while the read is outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_read_unit #(
    parameter int REG_W = 32,
    parameter int SEL_W = 3
) (
    input  logic            clock_4,
    input  logic            reset,
    reg_read_unit_if.slave  bus
);

    localparam logic [3:0] CMD_SINGLE = 4'h1;
    localparam logic [3:0] CMD_DUAL   = 4'h2;
    localparam logic [3:0] CMD_WRITE  = 4'h3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ_B = 2'd1,
        VALID  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [REG_W-1:0] operand_a_q, operand_a_d;
    logic [REG_W-1:0] operand_b_q, operand_b_d;
    logic [SEL_W-1:0] a_sel_q, a_sel_d;
    logic [SEL_W-1:0] b_sel_q, b_sel_d;
    // Remembers whether operand B belongs to a dual read; after a single
    // read operand B must stay zero even if b_sel happens to match a write.
    logic             dual_q, dual_d;

    logic [REG_W-1:0] bank [8];
    logic [REG_W-1:0] mux_src;
    logic [REG_W-1:0] mux_b;
    logic             cmd_write;

    // Bank inputs gathered into an array so the x86 encoding indexes directly
    always_comb begin
        bank[0] = bus.eax;
        bank[1] = bus.ecx;
        bank[2] = bus.edx;
        bank[3] = bus.ebx;
        bank[4] = bus.esp;
        bank[5] = bus.ebp;
        bank[6] = bus.esi;
        bank[7] = bus.edi;
    end

    // Combinational bank mux for the incoming source and the latched B select
    always_comb begin
        mux_src   = bank[bus.src_sel];
        mux_b     = bank[b_sel_q];
        cmd_write = (bus.read_or_write == CMD_WRITE);
    end

    // Next-state and next-operand logic
    always_comb begin
        state_d     = state_q;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        a_sel_d     = a_sel_q;
        b_sel_d     = b_sel_q;
        dual_d      = dual_q;

        case (state_q)
            IDLE: begin
                if (bus.read_or_write == CMD_SINGLE) begin
                    operand_a_d = mux_src;
                    operand_b_d = '0;
                    a_sel_d     = bus.src_sel;
                    dual_d      = 1'b0;
                    state_d     = VALID;
                end else if (bus.read_or_write == CMD_DUAL) begin
                    operand_a_d = mux_src;
                    a_sel_d     = bus.src_sel;
                    b_sel_d     = bus.dst_sel;
                    dual_d      = 1'b1;
                    state_d     = READ_B;
                end
            end

            READ_B: begin
                // Without forwarding the pre-write bank value is taken
                operand_b_d = mux_b;
`ifdef REG_READ_SNOOP_EN
                if (cmd_write && (bus.write_sel == b_sel_q)) begin
                    operand_b_d = bus.write_data;
                end
                if (cmd_write && (bus.write_sel == a_sel_q)) begin
                    operand_a_d = bus.write_data;
                end
`endif
                state_d = VALID;
            end

            VALID: begin
`ifdef REG_READ_SNOOP_EN
                if (cmd_write && (bus.write_sel == a_sel_q)) begin
                    operand_a_d = bus.write_data;
                end
                if (cmd_write && dual_q && (bus.write_sel == b_sel_q)) begin
                    operand_b_d = bus.write_data;
                end
`endif
                // New read commands here are dropped; only the ack matters
                if (bus.read_ack) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and operand registers with asynchronous reset
    always_ff @(posedge clock_4 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            operand_a_q <= '0;
            operand_b_q <= '0;
            a_sel_q     <= '0;
            b_sel_q     <= '0;
            dual_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            a_sel_q     <= a_sel_d;
            b_sel_q     <= b_sel_d;
            dual_q      <= dual_d;
        end
    end

`ifndef REG_READ_SNOOP_EN
    // Snoop inputs and the A-side bookkeeping only matter with forwarding on
    logic unused_snoop;
    assign unused_snoop = ^{bus.write_data, bus.write_sel, a_sel_q, dual_q, cmd_write};
`endif

    // Status flags come straight from the state register
    assign bus.operand_a  = operand_a_q;
    assign bus.operand_b  = operand_b_q;
    assign bus.read_valid = (state_q == VALID);
    assign bus.busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_reg_read_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_read_unit
// Description : Directed bench for reg_read_unit with a transaction-level
//               reference model and per-cycle comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_read_unit;

    logic clock_4 = 1'b0;
    logic reset   = 1'b0;

    int checks = 0;
    int errors = 0;

    reg_read_unit_if #(.REG_W(32), .SEL_W(3)) bus ();

    reg_read_unit #(.REG_W(32), .SEL_W(3)) dut (
        .clock_4 (clock_4),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clock_4 = ~clock_4;

`ifdef REG_READ_SNOOP_EN
    localparam bit SNOOP = 1'b1;
`else
    localparam bit SNOOP = 1'b0;
`endif

    // Register bank emulation: changes only through write commands
    logic [31:0] bank [8];
    assign bus.eax = bank[0];
    assign bus.ecx = bank[1];
    assign bus.edx = bank[2];
    assign bus.ebx = bank[3];
    assign bus.esp = bank[4];
    assign bus.ebp = bank[5];
    assign bus.esi = bank[6];
    assign bus.edi = bank[7];

    // Reference model: an outstanding read is "pending" from acceptance until
    // ack; operand B is "owed" for one edge after a dual read is accepted.
    bit          m_pending = 1'b0;
    bit          m_owe_b   = 1'b0;
    bit          m_dual    = 1'b0;
    int          m_asel    = 0;
    int          m_bsel    = 0;
    logic [31:0] m_a       = '0;
    logic [31:0] m_b       = '0;

    always @(posedge clock_4 or posedge reset) begin
        if (reset) begin
            m_pending = 1'b0; m_owe_b = 1'b0; m_dual = 1'b0;
            m_asel = 0; m_bsel = 0; m_a = '0; m_b = '0;
        end else begin
            bit wr;
            wr = (bus.read_or_write == 4'h3);
            if (!m_pending) begin
                if (bus.read_or_write == 4'h1) begin
                    m_a = bank[bus.src_sel]; m_b = '0; m_asel = int'(bus.src_sel);
                    m_dual = 1'b0; m_pending = 1'b1;
                end else if (bus.read_or_write == 4'h2) begin
                    m_a = bank[bus.src_sel]; m_asel = int'(bus.src_sel);
                    m_bsel = int'(bus.dst_sel); m_dual = 1'b1;
                    m_pending = 1'b1; m_owe_b = 1'b1;
                end
            end else begin
                if (m_owe_b) begin
                    m_b = (SNOOP && wr && int'(bus.write_sel) == m_bsel) ? bus.write_data : bank[m_bsel];
                    m_owe_b = 1'b0;
                end else begin
                    if (SNOOP && wr && m_dual && int'(bus.write_sel) == m_bsel) m_b = bus.write_data;
                    if (bus.read_ack) m_pending = 1'b0;
                end
                if (SNOOP && wr && int'(bus.write_sel) == m_asel) m_a = bus.write_data;
            end
            if (wr) bank[bus.write_sel] <= bus.write_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clock_4) begin
        chk("cmp_operand_a", bus.operand_a, m_a);
        chk("cmp_operand_b", bus.operand_b, m_b);
        chk("cmp_read_valid", {31'd0, bus.read_valid}, {31'd0, m_pending && !m_owe_b});
        chk("cmp_busy", {31'd0, bus.busy}, {31'd0, m_pending});
    end

    task automatic drv(input logic [3:0] cmd, input logic [2:0] src, input logic [2:0] dst,
                       input logic ack, input logic [2:0] wsel, input logic [31:0] wdata);
        bus.read_or_write = cmd;
        bus.src_sel       = src;
        bus.dst_sel       = dst;
        bus.read_ack      = ack;
        bus.write_sel     = wsel;
        bus.write_data    = wdata;
    endtask

    task automatic tick();
        @(posedge clock_4);
        #1;
    endtask

    task automatic idle();
        drv(4'h0, 3'd0, 3'd0, 1'b0, 3'd0, 32'h0);
    endtask

    initial begin
        logic [31:0] init_vals [8];
        init_vals = '{32'h0000_0999, 32'h1111_1111, 32'h0000_2222, 32'h0000_3333,
                      32'h0000_0044, 32'h0000_0055, 32'h0000_0066, 32'h7777_7777};
        idle();
        #1 reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("reset_operand_a", bus.operand_a, 32'h0);
        chk("reset_busy", {31'd0, bus.busy}, 32'h0);

        // Load the bank through the write port
        for (int i = 0; i < 8; i++) begin
            drv(4'h3, 3'd0, 3'd0, 1'b0, 3'(i), init_vals[i]);
            tick();
        end
        idle(); tick();
        chk("idle_after_writes", {31'd0, bus.busy}, 32'h0);

        // Single read of eax
        drv(4'h1, 3'd0, 3'd0, 1'b0, 3'd0, 32'h0); tick();
        chk("single_a", bus.operand_a, 32'h0000_0999);
        chk("single_b", bus.operand_b, 32'h0);
        chk("single_valid", {31'd0, bus.read_valid}, 32'h1);
        chk("single_busy", {31'd0, bus.busy}, 32'h1);
        drv(4'h0, 3'd0, 3'd0, 1'b1, 3'd0, 32'h0); tick();
        chk("ack_valid", {31'd0, bus.read_valid}, 32'h0);
        chk("ack_busy", {31'd0, bus.busy}, 32'h0);
        idle(); tick();

        // Dual read ecx / edi
        drv(4'h2, 3'd1, 3'd7, 1'b0, 3'd0, 32'h0); tick();
        chk("dual_busy_e1", {31'd0, bus.busy}, 32'h1);
        chk("dual_valid_e1", {31'd0, bus.read_valid}, 32'h0);
        idle(); tick();
        chk("dual_valid_e2", {31'd0, bus.read_valid}, 32'h1);
        chk("dual_a", bus.operand_a, 32'h1111_1111);
        chk("dual_b", bus.operand_b, 32'h7777_7777);
        drv(4'h0, 3'd0, 3'd0, 1'b1, 3'd0, 32'h0); tick();
        idle(); tick();

        // Commands while busy are dropped, including one alongside the ack
        drv(4'h1, 3'd2, 3'd0, 1'b0, 3'd0, 32'h0); tick();
        drv(4'h1, 3'd5, 3'd0, 1'b0, 3'd0, 32'h0); tick();
        chk("ignored_cmd_a", bus.operand_a, 32'h0000_2222);
        drv(4'h2, 3'd6, 3'd4, 1'b1, 3'd0, 32'h0); tick();
        chk("ack_with_cmd_busy", {31'd0, bus.busy}, 32'h0);
        chk("ack_with_cmd_a", bus.operand_a, 32'h0000_2222);
        idle(); tick();
        chk("dropped_cmd_idle", {31'd0, bus.busy}, 32'h0);

        // Write to edx while holding a single read of edx; write to edi
        // (stale B select) must leave operand B at zero
        drv(4'h1, 3'd2, 3'd0, 1'b0, 3'd0, 32'h0); tick();
        drv(4'h3, 3'd0, 3'd0, 1'b0, 3'd2, 32'hDEAD_BEEF); tick();
        chk("snoop_valid_a", bus.operand_a, SNOOP ? 32'hDEAD_BEEF : 32'h0000_2222);
        drv(4'h3, 3'd0, 3'd0, 1'b0, 3'd7, 32'h0000_5555); tick();
        chk("single_b_stays_zero", bus.operand_b, 32'h0);
        drv(4'h0, 3'd0, 3'd0, 1'b1, 3'd0, 32'h0); tick();
        idle(); tick();

        // Write to ebx on the operand-B capture edge
        drv(4'h2, 3'd0, 3'd3, 1'b0, 3'd0, 32'h0); tick();
        drv(4'h3, 3'd0, 3'd0, 1'b0, 3'd3, 32'h0000_00AB); tick();
        chk("snoop_readb_b", bus.operand_b, SNOOP ? 32'h0000_00AB : 32'h0000_3333);
        chk("snoop_readb_a", bus.operand_a, 32'h0000_0999);
        drv(4'h0, 3'd0, 3'd0, 1'b1, 3'd0, 32'h0); tick();
        idle(); tick();

        // Reset pulse while waiting for operand B
        drv(4'h2, 3'd1, 3'd2, 1'b0, 3'd0, 32'h0); tick();
        idle();
        reset = 1'b1;
        #1;
        chk("rst_mid_a", bus.operand_a, 32'h0);
        chk("rst_mid_b", bus.operand_b, 32'h0);
        chk("rst_mid_valid", {31'd0, bus.read_valid}, 32'h0);
        chk("rst_mid_busy", {31'd0, bus.busy}, 32'h0);
        #2 reset = 1'b0;
        tick();
        drv(4'h1, 3'd1, 3'd0, 1'b0, 3'd0, 32'h0); tick();
        chk("post_reset_a", bus.operand_a, 32'h1111_1111);
        chk("post_reset_valid", {31'd0, bus.read_valid}, 32'h1);
        drv(4'h0, 3'd0, 3'd0, 1'b1, 3'd0, 32'h0); tick();
        idle(); repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
